pcileech_sysctl: RTL and testbench

//  Parametrised board system controller between board pads and pcileech_com/pcileech_fifo/pcileech_pcie_a7.
//  - Debounces NUM_BTN raw buttons.
//  - Generates a stretched, synchronous-deassert system reset from rst_n and a reset button.
//  - Synchronises PCIe PERST#/PRSNT#.
//  - Drives NUM_LED LEDs with per-LED mode: off/on/activity-stretch/blink.

---
 rtl/pcileech_sysctl_pkg.sv | 25 ++
 rtl/pcileech_sysctl_if.sv | 29 ++
 rtl/pcileech_sysctl_debounce.sv | 60 ++++++
 rtl/pcileech_sysctl.sv | 233 +++++++++++++++++++++++
 tb/tb_pcileech_sysctl.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcileech_sysctl_pkg.sv
// pcileech_sysctl_pkg: shared types and helpers for the board system controller.
package pcileech_sysctl_pkg;

  // Per-LED drive mode, two bits per LED on the led_mode bus.
  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_ACT   = 2'd2,
    LED_BLINK = 2'd3
  } led_mode_t;

  // System reset sequencer states; sys_rst is asserted in every state except ST_RUN.
  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_HOLD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_BTN   = 2'd3
  } rst_state_t;

  // Width of a counter that must be able to hold the value max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pcileech_sysctl_if.sv
// pcileech_sysctl_if: signals exchanged between the system controller and the
// blocks it serves (debounced buttons, PCIe sideband, system reset, LED control).
// The controller takes the master modport; downstream logic takes slave.
interface pcileech_sysctl_if #(
  parameter int NUM_BTN = 2,
  parameter int NUM_LED = 2
);

  logic [NUM_BTN-1:0]   btn_level;
  logic [NUM_BTN-1:0]   btn_press;
  logic                 pcie_present_sync;
  logic                 pcie_perst_n_sync;
  logic                 sys_rst;
  logic [2*NUM_LED-1:0] led_mode;
  logic [NUM_LED-1:0]   led_act;
  logic                 led_invert;
  logic [NUM_LED-1:0]   led;

  modport master (
    output btn_level, btn_press, pcie_present_sync, pcie_perst_n_sync, sys_rst, led,
    input  led_mode, led_act, led_invert
  );

  modport slave (
    input  btn_level, btn_press, pcie_present_sync, pcie_perst_n_sync, sys_rst, led,
    output led_mode, led_act, led_invert
  );

endinterface

// File: rtl/pcileech_sysctl_debounce.sv
// pcileech_sysctl_debounce: one active-low button -> synchronised, debounced
// level (1 = pressed) and a single-cycle press pulse on each debounced 0->1.
module pcileech_sysctl_debounce
  import pcileech_sysctl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level_q;
  logic [CW-1:0] cnt;

  // Bring the asynchronous pad into the clock domain, inverted so 1 = pressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= ~btn_n;
      sync2 <= sync1;
    end
  end

  // Count consecutive cycles the input disagrees with the level; adopt it once stable long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      level <= sync2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Delayed copy of the level for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign press = level & ~level_q;

endmodule

// File: rtl/pcileech_sysctl.sv
// pcileech_sysctl: board system controller.
//  - debounces NUM_BTN raw buttons
//  - stretched system reset from rst_n and a reset button, synchronous deassert
//  - PCIe PERST#/PRSNT# synchronisation, enabled by macro PCILEECH_SYSCTL_PERST_EN
//    (when undefined the pads are ignored: perst_n_sync=1, present_sync=0 after reset)
//  - NUM_LED LEDs with per-LED off/on/activity-stretch/blink mode
// LED, debounce and blink logic are reset by rst_n only, never by sys_rst.
module pcileech_sysctl
  import pcileech_sysctl_pkg::*;
#(
  parameter int NUM_BTN         = 2,
  parameter int NUM_LED         = 2,
  parameter int RST_BTN_IDX     = 1,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RST_HOLD_CYCLES = 1024,
  parameter int STRETCH_CYCLES  = 5000000,
  parameter int BLINK_HALF      = 50000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_n,
  input  logic               pcie_present,
  input  logic               pcie_perst_n,
  pcileech_sysctl_if.master  bus
);

  localparam int HW = cnt_w(RST_HOLD_CYCLES);
  localparam int SW = cnt_w(STRETCH_CYCLES);
  localparam int BW = cnt_w(BLINK_HALF);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(RST_HOLD_CYCLES - 1);
  localparam logic [SW-1:0] ACT_LOAD   = SW'(STRETCH_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  // ---------------------------------------------------------------------------
  // Reset synchroniser: assert immediately, release two clocks after rst_n rises.
  // ---------------------------------------------------------------------------
  logic rst_meta_n;
  logic rst_sync_n;

  // Two-stage release synchroniser for rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_n <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta_n <= 1'b1;
      rst_sync_n <= rst_meta_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Buttons
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    pcileech_sysctl_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_n (btn_n[b]),
      .level (btn_level[b]),
      .press (btn_press[b])
    );
  end

  assign bus.btn_level = btn_level;
  assign bus.btn_press = btn_press;

  // ---------------------------------------------------------------------------
  // System reset sequencer
  // ---------------------------------------------------------------------------
  rst_state_t    state;
  rst_state_t    next_state;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] next_cnt;
  logic          sys_rst_q;
  logic          rst_btn;

  assign rst_btn = btn_level[RST_BTN_IDX];

  // State and hold counter registers; sys_rst is registered from the next state so it is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RESET;
      hold_cnt  <= '0;
      sys_rst_q <= 1'b1;
    end else begin
      state     <= next_state;
      hold_cnt  <= next_cnt;
      sys_rst_q <= (next_state != ST_RUN);
    end
  end

  // Next-state logic: hold reset for RST_HOLD_CYCLES after every reset source goes away.
  always_comb begin
    next_state = state;
    next_cnt   = hold_cnt;
    case (state)
      ST_RESET: begin
        if (rst_sync_n) begin
          next_state = ST_HOLD;
          next_cnt   = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (rst_btn) begin
          next_state = ST_BTN;
        end else if (hold_cnt == '0) begin
          next_state = ST_RUN;
        end else begin
          next_cnt = hold_cnt - 1'b1;
        end
      end
      ST_RUN: begin
        if (rst_btn) begin
          next_state = ST_BTN;
        end
      end
      ST_BTN: begin
        if (!rst_btn) begin
          next_state = ST_HOLD;
          next_cnt   = HOLD_LOAD;
        end
      end
      default: begin
        next_state = ST_RESET;
      end
    endcase
  end

  assign bus.sys_rst = sys_rst_q;

  // ---------------------------------------------------------------------------
  // PCIe sideband
  // ---------------------------------------------------------------------------
`ifdef PCILEECH_SYSCTL_PERST_EN
  logic [1:0] perst_sync;
  logic [1:0] present_sync;

  // Two-stage synchronisers for the asynchronous PERST# and PRSNT# pads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perst_sync   <= 2'b00;
      present_sync <= 2'b00;
    end else begin
      perst_sync   <= {perst_sync[0], pcie_perst_n};
      present_sync <= {present_sync[0], pcie_present};
    end
  end

  assign bus.pcie_perst_n_sync = perst_sync[1];
  assign bus.pcie_present_sync = present_sync[1];
`else
  logic perst_idle_n;
  logic unused_pcie_pads;

  // No sideband wiring on this board: report "not in reset" once out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perst_idle_n <= 1'b0;
    end else begin
      perst_idle_n <= 1'b1;
    end
  end

  assign unused_pcie_pads      = pcie_present ^ pcie_perst_n;
  assign bus.pcie_perst_n_sync = perst_idle_n;
  assign bus.pcie_present_sync = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // LEDs
  // ---------------------------------------------------------------------------
  logic [BW-1:0] blink_div;
  logic          blink_phase;

  // Shared blink divider; the phase flips every BLINK_HALF cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_div   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_div == BLINK_LAST) begin
      blink_div   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_div <= blink_div + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_LED; i++) begin : g_led
    logic [SW-1:0] act_cnt;
    logic          raw;
    logic          led_q;

    // Activity stretcher: each pulse (re)loads the full on-time, runs in every mode.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        act_cnt <= '0;
      end else if (bus.led_act[i]) begin
        act_cnt <= ACT_LOAD;
      end else if (act_cnt != '0) begin
        act_cnt <= act_cnt - 1'b1;
      end
    end

    // Select the unregistered LED value for the current mode.
    always_comb begin
      raw = 1'b0;
      case (led_mode_t'(bus.led_mode[2*i +: 2]))
        LED_OFF:   raw = 1'b0;
        LED_ON:    raw = 1'b1;
        LED_ACT:   raw = (act_cnt != '0);
        LED_BLINK: raw = blink_phase;
        default:   raw = 1'b0;
      endcase
    end

    // Registered LED drive with global polarity inversion.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        led_q <= 1'b0;
      end else begin
        led_q <= raw ^ bus.led_invert;
      end
    end

    assign bus.led[i] = led_q;
  end

endmodule

// File: tb/tb_pcileech_sysctl.sv
// tb_pcileech_sysctl: self-checking bench for pcileech_sysctl with small timing
// parameters. Expected per-cycle values are queued as stimulus is applied and
// popped for comparison after each clock edge.
module tb_pcileech_sysctl;
  import pcileech_sysctl_pkg::*;

  localparam int NUM_BTN = 2;
  localparam int NUM_LED = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NUM_BTN-1:0] btn_n = '1;
  logic               pcie_present = 1'b1;
  logic               pcie_perst_n = 1'b1;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb_q[$];

  pcileech_sysctl_if #(.NUM_BTN(NUM_BTN), .NUM_LED(NUM_LED)) bus ();

  pcileech_sysctl #(
    .NUM_BTN         (NUM_BTN),
    .NUM_LED         (NUM_LED),
    .RST_BTN_IDX     (1),
    .DEBOUNCE_CYCLES (4),
    .RST_HOLD_CYCLES (8),
    .STRETCH_CYCLES  (5),
    .BLINK_HALF      (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_n        (btn_n),
    .pcie_present (pcie_present),
    .pcie_perst_n (pcie_perst_n),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Release rst_n right after an edge and check sys_rst over the next 12 edges.
  task automatic release_and_check_sysrst(input string name);
    logic [7:0] exp;
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      sb_q.push_back({7'd0, (k <= 10)});
      tick();
      exp = sb_q.pop_front();
      checks++;
      if (bus.sys_rst !== exp[0]) begin
        failures++;
        $display("[TB] FAIL %s edge %0d: sys_rst got %b expected %b", name, k, bus.sys_rst, exp[0]);
      end
    end
  endtask

  task automatic test_reset();
    bus.led_mode   = 4'b0001;
    bus.led_act    = '0;
    bus.led_invert = 1'b0;
    btn_n          = '1;
    rst_n          = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.btn_level !== 2'b00) begin
      failures++; $display("[TB] FAIL reset_btn_level: got %b expected 00", bus.btn_level);
    end
    checks++;
    if (bus.btn_press !== 2'b00) begin
      failures++; $display("[TB] FAIL reset_btn_press: got %b expected 00", bus.btn_press);
    end
    checks++;
    if (bus.led !== 2'b00) begin
      failures++; $display("[TB] FAIL reset_led: got %b expected 00", bus.led);
    end
    checks++;
    if (bus.sys_rst !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_sys_rst: got %b expected 1", bus.sys_rst);
    end
    checks++;
    if ({bus.pcie_perst_n_sync, bus.pcie_present_sync} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_pcie_sync: got %b%b expected 00", bus.pcie_perst_n_sync, bus.pcie_present_sync);
    end
    bus.led_mode = 4'b0000;
    release_and_check_sysrst("reset_release");
  endtask

  task automatic test_debounce();
    logic [7:0] exp;
    // Glitch of three cycles must be rejected.
    btn_n[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 3) btn_n[0] = 1'b1;
      checks++;
      if ({bus.btn_level[0], bus.btn_press[0]} !== 2'b00) begin
        failures++;
        $display("[TB] FAIL debounce_glitch cycle %0d: level/press got %b%b expected 00",
                 k, bus.btn_level[0], bus.btn_press[0]);
      end
    end
    // Stable press: level after 2 sync + 4 debounce cycles, single press pulse.
    btn_n[0] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      sb_q.push_back({6'd0, (k >= 6), (k == 6)});
      tick();
      exp = sb_q.pop_front();
      checks++;
      if ({bus.btn_level[0], bus.btn_press[0]} !== exp[1:0]) begin
        failures++;
        $display("[TB] FAIL debounce_press cycle %0d: level/press got %b%b expected %b",
                 k, bus.btn_level[0], bus.btn_press[0], exp[1:0]);
      end
    end
    // Release: level falls with the same latency, no press pulse.
    btn_n[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      sb_q.push_back({6'd0, (k < 6), 1'b0});
      tick();
      exp = sb_q.pop_front();
      checks++;
      if ({bus.btn_level[0], bus.btn_press[0]} !== exp[1:0]) begin
        failures++;
        $display("[TB] FAIL debounce_release cycle %0d: level/press got %b%b expected %b",
                 k, bus.btn_level[0], bus.btn_press[0], exp[1:0]);
      end
    end
    checks++;
    if (bus.sys_rst !== 1'b0) begin
      failures++; $display("[TB] FAIL debounce_no_sysrst: got %b expected 0", bus.sys_rst);
    end
  endtask

  task automatic test_reset_button();
    logic [7:0] exp;
    btn_n[1] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      sb_q.push_back({6'd0, (k >= 6), (k >= 7)});
      tick();
      exp = sb_q.pop_front();
      checks++;
      if ({bus.btn_level[1], bus.sys_rst} !== exp[1:0]) begin
        failures++;
        $display("[TB] FAIL rstbtn_press cycle %0d: level/sys_rst got %b%b expected %b",
                 k, bus.btn_level[1], bus.sys_rst, exp[1:0]);
      end
    end
    btn_n[1] = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      sb_q.push_back({6'd0, (k < 6), (k < 15)});
      tick();
      exp = sb_q.pop_front();
      checks++;
      if ({bus.btn_level[1], bus.sys_rst} !== exp[1:0]) begin
        failures++;
        $display("[TB] FAIL rstbtn_release cycle %0d: level/sys_rst got %b%b expected %b",
                 k, bus.btn_level[1], bus.sys_rst, exp[1:0]);
      end
    end
  endtask

  task automatic test_led_act();
    logic [7:0] exp;
    bus.led_mode = {LED_OFF, LED_ACT};
    for (int c = 0; c <= 13; c++) begin
      bus.led_act[0] = (c == 0 || c == 5);
      sb_q.push_back({7'd0, (c >= 1 && c <= 10)});
      tick();
      exp = sb_q.pop_front();
      checks++;
      if (bus.led[0] !== exp[0]) begin
        failures++;
        $display("[TB] FAIL led_act cycle %0d: led0 got %b expected %b", c, bus.led[0], exp[0]);
      end
    end
    bus.led_act    = '0;
    bus.led_invert = 1'b1;
    tick();
    checks++;
    if (bus.led !== 2'b11) begin
      failures++; $display("[TB] FAIL led_invert_idle: got %b expected 11", bus.led);
    end
    bus.led_invert = 1'b0;
    tick();
    checks++;
    if (bus.led !== 2'b00) begin
      failures++; $display("[TB] FAIL led_invert_off: got %b expected 00", bus.led);
    end
  endtask

  task automatic test_led_blink();
    logic v[15];
    int   first;
    logic exp;
    bus.led_mode = {LED_BLINK, LED_OFF};
    for (int j = 0; j < 15; j++) begin
      tick();
      v[j] = bus.led[1];
    end
    first = -1;
    for (int j = 1; j <= 4; j++) begin
      if (first < 0 && v[j] !== v[j-1]) first = j;
    end
    checks++;
    if (first < 0) begin
      failures++; $display("[TB] FAIL blink_start: got no toggle expected toggle within 4 cycles");
    end else begin
      exp = v[first];
      for (int j = first + 1; j <= first + 9; j++) begin
        if (((j - first) % 3) == 0) exp = ~exp;
        checks++;
        if (v[j] !== exp) begin
          failures++; $display("[TB] FAIL blink_period sample %0d: got %b expected %b", j, v[j], exp);
        end
      end
    end
    bus.led_mode = {LED_OFF, LED_OFF};
    tick();
    checks++;
    if (bus.led[1] !== 1'b0) begin
      failures++; $display("[TB] FAIL blink_to_off: got %b expected 0", bus.led[1]);
    end
  endtask

  task automatic test_perst();
`ifdef PCILEECH_SYSCTL_PERST_EN
    pcie_perst_n = 1'b0;
    pcie_present = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.pcie_perst_n_sync, bus.pcie_present_sync} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL perst_low: got %b%b expected 00", bus.pcie_perst_n_sync, bus.pcie_present_sync);
    end
    pcie_perst_n = 1'b1;
    pcie_present = 1'b1;
    tick();
    checks++;
    if ({bus.pcie_perst_n_sync, bus.pcie_present_sync} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL perst_edge1: got %b%b expected 00", bus.pcie_perst_n_sync, bus.pcie_present_sync);
    end
    tick();
    checks++;
    if ({bus.pcie_perst_n_sync, bus.pcie_present_sync} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL perst_edge2: got %b%b expected 11", bus.pcie_perst_n_sync, bus.pcie_present_sync);
    end
`else
    for (int k = 0; k < 6; k++) begin
      pcie_perst_n = k[0];
      pcie_present = ~k[0];
      tick();
      checks++;
      if ({bus.pcie_perst_n_sync, bus.pcie_present_sync} !== 2'b10) begin
        failures++;
        $display("[TB] FAIL perst_const cycle %0d: got %b%b expected 10",
                 k, bus.pcie_perst_n_sync, bus.pcie_present_sync);
      end
    end
`endif
  endtask

  task automatic test_async_reset();
    bus.led_mode = {LED_OFF, LED_ON};
    btn_n[0]     = 1'b0;
    repeat (8) tick();
    checks++;
    if ({bus.btn_level[0], bus.led[0]} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL async_pre: level/led got %b%b expected 11", bus.btn_level[0], bus.led[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.sys_rst, bus.led, bus.btn_level} !== 5'b10000) begin
      failures++;
      $display("[TB] FAIL async_assert: sys_rst/led/level got %b expected 10000",
               {bus.sys_rst, bus.led, bus.btn_level});
    end
    tick();
    btn_n        = '1;
    bus.led_mode = '0;
    release_and_check_sysrst("async_release");
  endtask

  // Bound the whole run in case the design stalls the clocked sequence.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_debounce();
    test_reset_button();
    test_led_act();
    test_led_blink();
    test_perst();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
